// File: rtl/codificador_teclado_fifo.sv
// codificador_teclado_fifo: synchronised, debounced keypad priority encoder.
// Each debounced press yields one code (highest pressed key index wins), which is
// queued in a show-ahead FIFO read with a simple pop handshake.
module codificador_teclado_fifo #(
    parameter int N_TECLAS   = 10,
    parameter int LARG       = 4,
    parameter int DEB_CICLOS = 4,
    parameter int PROF       = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enablen,
    input  logic [N_TECLAS-1:0]        teclado,
    input  logic                       ler,
    output logic                       dado_valido,
    output logic [LARG-1:0]            codigo,
    output logic [$clog2(PROF+1)-1:0]  ocupacao,
    output logic                       cheio,
    output logic                       erro_overflow
);
    localparam int CNT_W = $clog2(DEB_CICLOS + 1);
    localparam int PTR_W = $clog2(PROF);
    localparam int OCP_W = $clog2(PROF + 1);

    typedef enum logic [1:0] {OCIOSO, CONTANDO, PRESSIONADO, LIBERANDO} estado_t;

    logic [N_TECLAS-1:0] sinc1_q, sinc2_q;
    logic [N_TECLAS-1:0] vet;
    logic                alguma;
    logic [LARG-1:0]     cod;

    estado_t             estado_q, estado_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LARG-1:0]     cand_q, cand_d;
    logic                evento;

    logic [LARG-1:0]     mem_q [PROF];
    logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [OCP_W-1:0]    ocup_q, ocup_d;
    logic                erro_q, erro_d;
    logic                vazio, cheio_int, pop, push;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sinc1_q <= '0;
            sinc2_q <= '0;
        end else begin
            sinc1_q <= teclado;
            sinc2_q <= sinc1_q;
        end
    end

    // Enable masking and priority encoding; the last (highest) set bit wins.
    always_comb begin
        vet    = enablen ? '0 : sinc2_q;
        alguma = |vet;
        cod    = '0;
        for (int i = 0; i < N_TECLAS; i++) begin
            if (vet[i]) cod = LARG'(i);
        end
    end

    // Debounce state, stable-cycle counter and candidate code registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            cand_q   <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
        end
    end

    // Debounce next state: one event per accepted press, rollover and bounces ignored.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        evento   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (alguma) begin
                    estado_d = CONTANDO;
                    cand_d   = cod;
                    cnt_d    = CNT_W'(1);
                end
            end
            CONTANDO: begin
                if (!alguma) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else if (cod != cand_q) begin
                    cand_d = cod;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q + CNT_W'(1) == CNT_W'(DEB_CICLOS)) begin
                    evento   = 1'b1;
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSIONADO: begin
                if (!alguma) begin
                    estado_d = LIBERANDO;
                    cnt_d    = CNT_W'(1);
                end
            end
            LIBERANDO: begin
                if (alguma) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = '0;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(DEB_CICLOS)) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase
    end

    // FIFO control: a pop frees the slot a simultaneous push may use even when full.
    always_comb begin
        vazio     = (ocup_q == '0);
        cheio_int = (ocup_q == OCP_W'(PROF));
        pop       = ler && !vazio;
        push      = evento && (!cheio_int || pop);
        erro_d    = erro_q | (evento && cheio_int && !pop);
        wr_d      = wr_q;
        rd_d      = rd_q;
        ocup_d    = ocup_q;
        if (push) wr_d = (wr_q == PTR_W'(PROF - 1)) ? '0 : wr_q + PTR_W'(1);
        if (pop)  rd_d = (rd_q == PTR_W'(PROF - 1)) ? '0 : rd_q + PTR_W'(1);
        if (push && !pop)      ocup_d = ocup_q + OCP_W'(1);
        else if (pop && !push) ocup_d = ocup_q - OCP_W'(1);
    end

    // FIFO pointers, fill level and sticky overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ocup_q <= '0;
            erro_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ocup_q <= ocup_d;
            erro_q <= erro_d;
        end
    end

    // FIFO storage; contents are only visible through codigo while non-empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand_q;
    end

    assign dado_valido   = !vazio;
    assign codigo        = vazio ? '0 : mem_q[rd_q];
    assign ocupacao      = ocup_q;
    assign cheio         = cheio_int;
    assign erro_overflow = erro_q;

endmodule

// File: tb/tb_codificador_teclado_fifo.sv
// Testbench for codificador_teclado_fifo: directed tables, corner sequences and
// random stimulus checked every cycle against a run-length/queue reference model.
module tb_codificador_teclado_fifo;
    localparam int N = 10, LARG = 4, DEB = 4, PROF = 4;

    logic            clk = 1'b0, resetn = 1'b1, enablen = 1'b0, ler = 1'b0;
    logic [N-1:0]    teclado = '0;
    logic            dado_valido, cheio, erro_overflow;
    logic [LARG-1:0] codigo;
    logic [2:0]      ocupacao;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [N-1:0] samp_q[$];
    int           fila[$];
    bit           ovf, armed;
    int           code_val, code_len, zero_run;

    typedef struct {
        logic [N-1:0] tec;
        logic         en_n;
        int           n_ev;
        int           code;
    } vec_t;
    vec_t tab[6];

    codificador_teclado_fifo #(.N_TECLAS(N), .LARG(LARG), .DEB_CICLOS(DEB), .PROF(PROF)) dut (
        .clk(clk), .resetn(resetn), .enablen(enablen), .teclado(teclado), .ler(ler),
        .dado_valido(dado_valido), .codigo(codigo), .ocupacao(ocupacao),
        .cheio(cheio), .erro_overflow(erro_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int hi_idx(logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        samp_q.delete();
        fila.delete();
        ovf = 0; armed = 1; code_val = -1; code_len = 0; zero_run = 0;
    endtask

    // Event when one code has been seen DEB samples in a row while armed;
    // re-armed once the keypad has read empty DEB samples in a row.
    task automatic model_step();
        logic [N-1:0] v;
        int c;
        bit evt, popm, full_before;
        if (!resetn) begin
            model_reset();
            return;
        end
        v = (enablen || samp_q.size() < 2) ? '0 : samp_q[0];
        samp_q.push_back(teclado);
        if (samp_q.size() > 2) void'(samp_q.pop_front());
        c = hi_idx(v);
        evt = 0;
        if (c < 0) begin
            zero_run++;
            code_len = 0;
        end else begin
            zero_run = 0;
            if (code_len > 0 && c == code_val) code_len++;
            else begin
                code_val = c;
                code_len = 1;
            end
        end
        if (armed) begin
            if (c >= 0 && code_len == DEB) begin
                evt = 1;
                armed = 0;
            end
        end else if (zero_run == DEB) begin
            armed = 1;
        end
        full_before = (fila.size() == PROF);
        popm = ler && fila.size() > 0;
        if (popm) void'(fila.pop_front());
        if (evt) begin
            if (!full_before || popm) fila.push_back(code_val);
            else ovf = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_valid", int'(dado_valido), int'(fila.size() != 0));
        chk("m_codigo", int'(codigo), (fila.size() != 0) ? fila[0] : 0);
        chk("m_ocup", int'(ocupacao), fila.size());
        chk("m_cheio", int'(cheio), int'(fila.size() == PROF));
        chk("m_erro", int'(erro_overflow), int'(ovf));
    endtask

    task automatic do_reset();
        ler = 0; teclado = '0; enablen = 0;
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic press(int k, int hold, int rel);
        teclado = N'(1) << k;
        repeat (hold) tick();
        teclado = '0;
        repeat (rel) tick();
    endtask

    task automatic pop_chk(int exp);
        chk("pop_code", int'(codigo), exp);
        ler = 1;
        tick();
        ler = 0;
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_valid"}, int'(dado_valido), 0);
        chk({nm, "_codigo"}, int'(codigo), 0);
        chk({nm, "_ocup"}, int'(ocupacao), 0);
        chk({nm, "_cheio"}, int'(cheio), 0);
        chk({nm, "_erro"}, int'(erro_overflow), 0);
    endtask

    initial begin
        tab[0] = '{10'b0000001000, 1'b0, 1, 3};
        tab[1] = '{10'b1000001001, 1'b0, 1, 9};
        tab[2] = '{10'b1000001001, 1'b1, 0, 0};
        tab[3] = '{10'b0000000001, 1'b0, 1, 0};
        tab[4] = '{10'b0100000000, 1'b0, 1, 8};
        tab[5] = '{10'b0000110000, 1'b0, 1, 5};

        // Power-on reset, checked before any clock edge
        #2 resetn = 0;
        #1 chk_zero("rst0");
        model_reset();
        @(negedge clk);
        tick();
        resetn = 1;

        // Single key latency: push lands on E5
        teclado = 10'b0000001000;
        repeat (5) tick();
        chk("lat_E4_valid", int'(dado_valido), 0);
        tick();
        chk("lat_E5_valid", int'(dado_valido), 1);
        chk("lat_E5_codigo", int'(codigo), 3);
        chk("lat_E5_ocup", int'(ocupacao), 1);
        repeat (4) tick();
        teclado = '0;
        repeat (8) tick();
        chk("single_once", int'(ocupacao), 1);
        pop_chk(3);
        chk("single_empty", int'(dado_valido), 0);
        chk("single_cod0", int'(codigo), 0);

        // Table of single presses
        for (int i = 0; i < 6; i++) begin
            do_reset();
            enablen = tab[i].en_n;
            teclado = tab[i].tec;
            repeat (10) tick();
            teclado = '0;
            repeat (8) tick();
            enablen = 0;
            tick();
            chk($sformatf("tab%0d_ocup", i), int'(ocupacao), tab[i].n_ev);
            chk($sformatf("tab%0d_code", i), int'(codigo), tab[i].code);
        end

        // Async reset while pressed with a non-empty FIFO
        do_reset();
        teclado = N'(1) << 6;
        repeat (8) tick();
        chk("prerst_valid", int'(dado_valido), 1);
        #2 resetn = 0;
        #1 chk_zero("midrst");
        model_reset();
        teclado = '0;
        tick();
        tick();
        resetn = 1;
        repeat (12) tick();
        chk("postrst_ocup", int'(ocupacao), 0);

        // Enable dropped during a held key acts as release
        do_reset();
        teclado = N'(1) << 7;
        repeat (8) tick();
        enablen = 1;
        repeat (8) tick();
        teclado = '0;
        repeat (3) tick();
        enablen = 0;
        repeat (8) tick();
        chk("en_ocup", int'(ocupacao), 1);
        chk("en_code", int'(codigo), 7);

        // Bouncing key 5 then stable
        do_reset();
        for (int i = 0; i < 4; i++) begin
            teclado = N'(1) << 5; repeat (2) tick();
            teclado = '0;         repeat (2) tick();
        end
        press(5, 10, 8);
        chk("bounce_ocup", int'(ocupacao), 1);
        chk("bounce_code", int'(codigo), 5);

        // One-cycle glitch while releasing
        do_reset();
        teclado = N'(1) << 2;
        repeat (10) tick();
        teclado = '0;
        repeat (2) tick();
        teclado = N'(1) << 2;
        tick();
        teclado = '0;
        repeat (10) tick();
        chk("glitch_ocup", int'(ocupacao), 1);
        chk("glitch_code", int'(codigo), 2);

        // Overflow
        do_reset();
        press(1, 8, 8); press(2, 8, 8); press(3, 8, 8); press(4, 8, 8); press(6, 8, 8);
        chk("ovf_ocup", int'(ocupacao), 4);
        chk("ovf_cheio", int'(cheio), 1);
        chk("ovf_erro", int'(erro_overflow), 1);
        pop_chk(1); pop_chk(2); pop_chk(3); pop_chk(4);
        chk("ovf_drained", int'(dado_valido), 0);
        chk("ovf_sticky", int'(erro_overflow), 1);

        // Full FIFO, pop on the push edge
        do_reset();
        press(1, 8, 8); press(2, 8, 8); press(3, 8, 8); press(4, 8, 8);
        chk("full_cheio", int'(cheio), 1);
        teclado = N'(1) << 5;
        repeat (5) tick();
        ler = 1;
        tick();
        ler = 0;
        chk("pp_ocup", int'(ocupacao), 4);
        chk("pp_erro", int'(erro_overflow), 0);
        repeat (4) tick();
        teclado = '0;
        repeat (8) tick();
        pop_chk(2); pop_chk(3); pop_chk(4); pop_chk(5);
        chk("pp_empty", int'(dado_valido), 0);
        press(7, 8, 8);
        pop_chk(7);
        chk("pp_wrap_empty", int'(ocupacao), 0);

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: teclado = '0;
                    1: teclado = N'(1) << $urandom_range(0, N - 1);
                    2: teclado = N'($urandom);
                    default: ;
                endcase
            end
            ler = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 40) == 0) enablen = ~enablen;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
